// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state type for the uart transmit arbiter
package uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic ARB_IDLE      = 1'b0;
    localparam logic ARB_GRANT     = 1'b1;
    localparam int   ARB_MAX_BURST = 16;

    typedef enum logic {
        S_IDLE  = ARB_IDLE,
        S_GRANT = ARB_GRANT
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational rotate-priority picker starting after the last holder
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic               o_found,
    output logic [ID_W-1:0]    o_index
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest set request after i_last wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_idx   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = (int'(i_last) + k) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_found = 1'b1;
                o_index = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst arbiter sharing one uart_tx between requesters
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = UART_DATA_W,
    parameter int MAX_BURST = ARB_MAX_BURST,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      grant_active,
    output logic [ID_W-1:0]           grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       r_state;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  r_last_grant;
    logic             r_grant_active;
    logic [CNT_W-1:0] r_burst_cnt;

    logic             w_found;
    logic [ID_W-1:0]  w_pick;
    logic             w_in_grant;
    logic             w_handshake;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_release;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_last  (r_last_grant),
        .o_found (w_found),
        .o_index (w_pick)
    );

    assign w_in_grant   = (r_state == S_GRANT);
    assign tx_valid     = w_in_grant & req_valid[r_grant_id];
    assign w_handshake  = tx_valid & tx_ready;
    assign w_cnt_next   = r_burst_cnt + 1'b1;
    // Burst ends on last byte, on hitting the burst limit, or when the holder goes quiet.
    assign w_release    = w_in_grant &
                          ((w_handshake & (req_last[r_grant_id] | (w_cnt_next == CNT_W'(MAX_BURST)))) |
                           ~req_valid[r_grant_id]);
    assign grant_active = r_grant_active;
    assign grant_id     = r_grant_id;

    // Steer the holder's byte to the transmitter; zero when nothing is offered.
    always_comb begin
        tx_data = '0;
        if (tx_valid) begin
            tx_data = req_data[int'(r_grant_id)*DATA_W +: DATA_W];
        end
    end

    // Only the holder sees the transmitter's ready.
    always_comb begin
        req_ready = '0;
        if (w_in_grant) begin
            req_ready[r_grant_id] = tx_ready;
        end
    end

    // Arbitration FSM: one IDLE cycle per grant, grant held until a release condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_grant_id     <= '0;
            r_last_grant   <= ID_W'(NUM_REQ - 1);
            r_grant_active <= 1'b0;
            r_burst_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && w_found) begin
                        r_grant_id     <= w_pick;
                        r_grant_active <= 1'b1;
                        r_burst_cnt    <= '0;
                        r_state        <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_handshake) begin
                        r_burst_cnt <= w_cnt_next;
                    end
                    if (w_release) begin
                        r_last_grant   <= r_grant_id;
                        r_grant_active <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    r_grant_active <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        grant_active;
    logic [1:0]  grant_id;

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .MAX_BURST (16),
        .ID_W      (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .grant_active (grant_active),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] rq[4][$];
    logic [7:0] log_data[$];
    logic [1:0] log_id[$];
    int         grant_q[$];
    int         gap_q[$];
    int         idle_cnt;
    logic       prev_ga;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_data[i*8 +: 8]   = rq[i][0][7:0];
                req_last[i]          = rq[i][0][8];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*8 +: 8]   = 8'h00;
                req_last[i]          = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic cycle();
        logic [3:0] pops;
        logic [8:0] tmp;
        pops = req_valid & req_ready;
        if (tx_valid && tx_ready) begin
            log_data.push_back(tx_data);
            log_id.push_back(grant_id);
        end
        if (grant_active && !prev_ga) begin
            grant_q.push_back(int'(grant_id));
            gap_q.push_back(idle_cnt);
        end
        if (grant_active) idle_cnt = 0;
        else idle_cnt++;
        prev_ga = grant_active;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (pops[i]) tmp = rq[i].pop_front();
        end
        refresh();
        #1;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        enable   = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) rq[i].delete();
        refresh();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_data.delete();
        log_id.delete();
        grant_q.delete();
        gap_q.delete();
        idle_cnt = 0;
        prev_ga  = 1'b0;
        #1;
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        logic done;
        done = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
                rq[3].size() == 0 && !grant_active) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        check(tag, done, 1'b1);
    endtask

    int bad;

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        tx_ready  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset state
        reset_dut();
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_grant_active", grant_active, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_tx_data", tx_data, 8'h00);

        // Single requester, two-byte message
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b1);
        refresh();
        #1;
        check("single_no_grant_yet", grant_active, 1'b0);
        cycle();
        check("single_grant_active", grant_active, 1'b1);
        check("single_grant_id", grant_id, 2'd1);
        check("single_byte0", tx_data, 8'h41);
        check("single_ready", req_ready, 4'b0010);
        cycle();
        check("single_byte1", tx_data, 8'h42);
        cycle();
        check("single_release", grant_active, 1'b0);
        check("single_id_kept", grant_id, 2'd1);
        check("single_hs_count", log_data.size(), 2);
        check("single_log1", log_data[1], 8'h42);

        // All four requesters, one-byte messages
        reset_dut();
        push(0, 8'hA0, 1'b1);
        push(0, 8'hB0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        refresh();
        #1;
        run_until_idle("rr_done", 60);
        check("rr_grants", grant_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_order%0d", i), grant_q[i], (i == 4) ? 0 : i);
        end
        for (int i = 1; i < 5; i++) begin
            check($sformatf("rr_gap%0d", i), gap_q[i], 1);
        end
        check("rr_data4", log_data[4], 8'hB0);
        check("rr_data2", log_data[2], 8'hA2);

        // Burst limit forces re-arbitration after 16 bytes
        reset_dut();
        for (int k = 0; k < 20; k++) push(2, 8'h10 + 8'(k), 1'b0);
        push(3, 8'h33, 1'b1);
        refresh();
        #1;
        run_until_idle("burst_done", 80);
        check("burst_total", log_data.size(), 21);
        check("burst_b15_data", log_data[15], 8'h1F);
        check("burst_b15_id", log_id[15], 2'd2);
        check("burst_r3_data", log_data[16], 8'h33);
        check("burst_r3_id", log_id[16], 2'd3);
        check("burst_resume_data", log_data[17], 8'h20);
        check("burst_resume_id", log_id[17], 2'd2);
        check("burst_grants", grant_q.size(), 3);
        check("burst_order1", grant_q[1], 3);
        check("burst_order2", grant_q[2], 2);

        // Backpressure mid-message
        reset_dut();
        push(1, 8'h51, 1'b0);
        push(1, 8'h52, 1'b0);
        push(1, 8'h53, 1'b1);
        refresh();
        #1;
        cycle();
        cycle();
        tx_ready = 1'b0;
        #1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h52 || req_ready !== 4'b0000) bad++;
            cycle();
        end
        check("bp_stable", bad, 0);
        check("bp_no_transfer", log_data.size(), 1);
        check("bp_held", grant_active, 1'b1);
        tx_ready = 1'b1;
        #1;
        check("bp_ready_back", req_ready, 4'b0010);
        cycle();
        check("bp_transfer", log_data.size(), 2);
        check("bp_byte", log_data[1], 8'h52);
        run_until_idle("bp_done", 20);
        check("bp_total", log_data.size(), 3);

        // Valid drop without last
        reset_dut();
        push(0, 8'h61, 1'b0);
        push(0, 8'h62, 1'b0);
        push(0, 8'h63, 1'b0);
        push(1, 8'h71, 1'b1);
        refresh();
        #1;
        repeat (4) cycle();
        check("drop_count", log_data.size(), 3);
        check("drop_tx_valid", tx_valid, 1'b0);
        check("drop_still_held", grant_active, 1'b1);
        cycle();
        check("drop_release", grant_active, 1'b0);
        cycle();
        check("drop_next_active", grant_active, 1'b1);
        check("drop_next_id", grant_id, 2'd1);
        check("drop_next_data", tx_data, 8'h71);

        // Asynchronous reset mid-burst
        reset_dut();
        for (int k = 0; k < 5; k++) push(2, 8'hC0 + 8'(k), (k == 4));
        refresh();
        #1;
        cycle();
        cycle();
        check("arst_pre_valid", tx_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_grant_active", grant_active, 1'b0);
        check("arst_req_ready", req_ready, 4'b0000);
        check("arst_tx_data", tx_data, 8'h00);

        // enable low blocks new grants but not a running burst
        reset_dut();
        enable = 1'b0;
        push(1, 8'h81, 1'b0);
        push(1, 8'h82, 1'b0);
        push(1, 8'h83, 1'b1);
        push(3, 8'h93, 1'b1);
        refresh();
        #1;
        repeat (5) cycle();
        check("en_blocked", grant_active, 1'b0);
        check("en_blocked_hs", log_data.size(), 0);
        enable = 1'b1;
        #1;
        cycle();
        check("en_grant", grant_active, 1'b1);
        check("en_grant_id", grant_id, 2'd1);
        enable = 1'b0;
        #1;
        repeat (10) cycle();
        check("en_burst_done", log_data.size(), 3);
        check("en_burst_last", log_data[2], 8'h83);
        check("en_no_new_grant", grant_active, 1'b0);
        enable = 1'b1;
        #1;
        run_until_idle("en_resume_done", 20);
        check("en_resume_data", log_data[3], 8'h93);
        check("en_resume_id", log_id[3], 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
